mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port front end for the cache/RAM memory module: shares the single memory port between an instruction-fetch requester (read-only) and a data requester (read/write). It arbitrates round-robin, issues the one-cycle `start` pulse with a command, waits for `dataReady`, returns read data with a one-cycle acknowledge, and flags a timeout if the memory never responds. It sits between the processor core and the memory module.

## Interface
- `ramWidth`, 8, data word width (matches memory module)
- `addrSize`, 8, address width (matches memory module)
- `timeoutCycles`, 64, maximum WAIT cycles before abort (≥4)

One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, rising edge
- `clr`  in  1  asynchronous active-high reset
- `f_req`  in  1  fetch request, held until `f_ack`
- `f_addr`  in  addrSize  fetch address
- `f_indirect`  in  1  fetch indirect-addressing flag
- `f_ack`  out  1  one-cycle completion pulse
- `f_rdata`  out  ramWidth  fetch read data, valid with `f_ack`, held after
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  addrSize  data address
- `d_wdata`  in  ramWidth  write data
- `d_indirect`  in  1  data indirect flag
- `d_ack`  out  1  one-cycle completion pulse
- `d_rdata`  out  ramWidth  data read result, valid with `d_ack`, held after
- `mem_start`  out  1  to memory `start`
- `mem_cntrl`  out  2  to memory `cntrl`
- `mem_addr`  out  addrSize  to memory `addr`
- `mem_dataIn`  out  ramWidth  to memory `dataIn`
- `mem_isIndirect`  out  1  to memory `isIndirect`
- `mem_dataOut`  in  ramWidth  from memory `dataOut`
- `mem_dataReady`  in  1  from memory `dataReady`
- `busy`  out  1  state ≠ IDLE
- `timeout_err`  out  1  pulses with the ack of a timed-out transaction

## Operation
- `mem_cntrl` encoding: NOP = 2'b00, READ = 2'b01, WRITE = 2'b10; fetch always issues READ.
- States: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE: if any request is pending, grant one. If both are pending, grant the port not granted last (`last_grant` resets to DATA, so fetch wins the first tie). On grant, latch addr, cmd, wdata and indirect into registers, then go to ISSUE.
- ISSUE: `mem_start` = 1 for exactly this cycle. The `mem_*` command outputs are driven from the latched registers, valid from ISSUE through WAIT. Go to WAIT and clear `tcnt`.
- WAIT: `tcnt` increments each cycle. `mem_dataReady` is ignored in the first WAIT cycle (guard against a stale ready).
  - From the second WAIT cycle, `mem_dataReady` = 1: capture `mem_dataOut` into the granted port's rdata (reads only), then go to DONE.
  - Else if `tcnt` == timeoutCycles-1: go to DONE with the error flag set.
  - If `mem_dataReady` and the timeout occur in the same cycle, `mem_dataReady` wins and no error is flagged.
- DONE: the granted port's ack = 1 and `timeout_err` = error flag. Update `last_grant`, then go to IDLE. On timeout, rdata is unchanged.
- Requester contract:
  - Inputs are sampled only at grant.
  - A request dropped after grant still completes and is still acked.
  - A request still high in the cycle after its ack is treated as a new request.
- In IDLE and DONE: `mem_cntrl` = NOP and `mem_start` = 0. `mem_addr`, `mem_dataIn` and `mem_isIndirect` hold their last latched values.

## Timing
- Reset values (immediate on `clr`):
  - state IDLE
  - all acks, `mem_start`, `busy` and `timeout_err` = 0
  - `mem_cntrl` = NOP
  - addr, data and rdata registers = 0
- Reset mid-transaction aborts with no ack. The top level ties `clr` to the memory's clear so the two stay consistent.
- Minimum latency: `req` seen in IDLE in cycle 0 → ISSUE in cycle 1 → WAIT in cycles 2–3 (ready accepted in cycle 3) → ack in cycle 4.
- Minimum back-to-back spacing is 5 cycles per transaction.
- Timeout: ack with error in cycle timeoutCycles+2 after the request in cycle 0.
- Starvation bound: with both ports requesting continuously, they alternate strictly.

## Structure
- Package `mem_arb_pkg`:
  - `mem_cntrl` encodings (NOP/READ/WRITE)
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - grant id (FETCH = 0, DATA = 1)
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from `f_req`, `d_req` and `last_grant`. All remaining logic goes in the top level.
- Timeout counter width is $clog2(timeoutCycles).

## Test plan
- Fetch read, addr 8'h10, memory returns 8'hA5 on the 2nd WAIT cycle → `mem_start` pulses in cycle 1 with `mem_cntrl` = 01; `f_ack` in cycle 4; `f_rdata` = 8'hA5.
- Data write, addr 8'h22, wdata 8'h3C → `mem_cntrl` = 10, `mem_dataIn` = 8'h3C, `d_ack` after ready; `d_rdata` unchanged.
- `f_req` and `d_req` both held high for 4 transactions → grant order F, D, F, D; no ack overlap.
- `mem_dataReady` never asserted, timeoutCycles = 8 → single `d_ack` together with `timeout_err` = 1 at cycle 10; returns to IDLE.
- `mem_dataReady` held high entering WAIT (stale) → ignored in the first WAIT cycle; ack at cycle 4, not 3.
- `clr` asserted during WAIT → outputs go to reset values immediately; no ack; next request is served normally from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter:
// memory command codes, FSM states and grant ids.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      NOP   = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10
   } cntrl_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between core, arbiter and memory module.
// slave: arbiter view; master: core + memory view.
interface mem_port_arbiter_if #(
   parameter int ramWidth = 8,
   parameter int addrSize = 8
);
   logic                f_req;
   logic [addrSize-1:0] f_addr;
   logic                f_indirect;
   logic                f_ack;
   logic [ramWidth-1:0] f_rdata;

   logic                d_req;
   logic                d_we;
   logic [addrSize-1:0] d_addr;
   logic [ramWidth-1:0] d_wdata;
   logic                d_indirect;
   logic                d_ack;
   logic [ramWidth-1:0] d_rdata;

   logic                mem_start;
   logic [1:0]          mem_cntrl;
   logic [addrSize-1:0] mem_addr;
   logic [ramWidth-1:0] mem_dataIn;
   logic                mem_isIndirect;
   logic [ramWidth-1:0] mem_dataOut;
   logic                mem_dataReady;

   logic                busy;
   logic                timeout_err;

   modport slave (
      input  f_req, f_addr, f_indirect,
      output f_ack, f_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_indirect,
      output d_ack, d_rdata,
      output mem_start, mem_cntrl, mem_addr,
      output mem_dataIn, mem_isIndirect,
      input  mem_dataOut, mem_dataReady,
      output busy, timeout_err
   );

   modport master (
      output f_req, f_addr, f_indirect,
      input  f_ack, f_rdata,
      output d_req, d_we, d_addr, d_wdata, d_indirect,
      input  d_ack, d_rdata,
      input  mem_start, mem_cntrl, mem_addr,
      input  mem_dataIn, mem_isIndirect,
      output mem_dataOut, mem_dataReady,
      input  busy, timeout_err
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin pick.
// Ports: i_f_req, i_d_req, i_last -> o_valid, o_grant.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic   i_f_req,
   input  logic   i_d_req,
   input  grant_t i_last,
   output logic   o_valid,
   output grant_t o_grant
);

   always_comb begin
      o_valid = i_f_req | i_d_req;
      o_grant = FETCH;
      unique case (1'b1)
         (i_f_req & i_d_req):  o_grant = grant_t'(~i_last);
         (i_d_req & ~i_f_req): o_grant = DATA;
         default:              o_grant = FETCH;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters.
// Ports: clk, clr (async high), bus (slave modport).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ramWidth      = 8,
   parameter int addrSize      = 8,
   parameter int timeoutCycles = 64
) (
   input logic               clk,
   input logic               clr,
   mem_port_arbiter_if.slave bus
);

   localparam int TW = $clog2(timeoutCycles);
   localparam logic [TW-1:0] TLAST = TW'(timeoutCycles - 1);

   state_t              r_state;
   state_t              w_next;
   grant_t              r_grant;
   grant_t              r_last;
   grant_t              w_pick;
   logic                w_valid;
   cntrl_t              r_cmd;
   logic [addrSize-1:0] r_addr;
   logic [ramWidth-1:0] r_wdata;
   logic [ramWidth-1:0] r_f_rdata;
   logic [ramWidth-1:0] r_d_rdata;
   logic                r_ind;
   logic                r_err;
   logic [TW-1:0]       r_tcnt;
   logic                w_rdy;
   logic                w_tmo;

   rr_arbiter2 u_rr (
      .i_f_req (bus.f_req),
      .i_d_req (bus.d_req),
      .i_last  (r_last),
      .o_valid (w_valid),
      .o_grant (w_pick)
   );

   // tcnt is 0 in the first WAIT cycle: a ready there is stale
   assign w_rdy = bus.mem_dataReady && (r_tcnt != '0);
   assign w_tmo = (r_tcnt == TLAST);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state   <= IDLE;
         r_grant   <= FETCH;
         r_last    <= DATA;
         r_cmd     <= NOP;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_f_rdata <= '0;
         r_d_rdata <= '0;
         r_ind     <= 1'b0;
         r_err     <= 1'b0;
         r_tcnt    <= '0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_grant <= w_pick;
                  if (w_pick == DATA) begin
                     r_cmd   <= bus.d_we ? WRITE : READ;
                     r_addr  <= bus.d_addr;
                     r_wdata <= bus.d_wdata;
                     r_ind   <= bus.d_indirect;
                  end else begin
                     r_cmd  <= READ;
                     r_addr <= bus.f_addr;
                     r_ind  <= bus.f_indirect;
                  end
               end
            end
            ISSUE: r_tcnt <= '0;
            WAIT: begin
               r_tcnt <= r_tcnt + TW'(1);
               // ready wins over a same-cycle timeout
               r_err  <= !w_rdy && w_tmo;
               if (w_rdy && r_cmd == READ) begin
                  if (r_grant == DATA)
                     r_d_rdata <= bus.mem_dataOut;
                  else
                     r_f_rdata <= bus.mem_dataOut;
               end
            end
            DONE: r_last <= r_grant;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next          = r_state;
      bus.mem_start   = 1'b0;
      bus.mem_cntrl   = NOP;
      bus.f_ack       = 1'b0;
      bus.d_ack       = 1'b0;
      bus.timeout_err = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_valid) w_next = ISSUE;
         end
         ISSUE: begin
            bus.mem_start = 1'b1;
            bus.mem_cntrl = r_cmd;
            w_next        = WAIT;
         end
         WAIT: begin
            bus.mem_cntrl = r_cmd;
            if (w_rdy || w_tmo) w_next = DONE;
         end
         DONE: begin
            bus.f_ack       = (r_grant == FETCH);
            bus.d_ack       = (r_grant == DATA);
            bus.timeout_err = r_err;
            w_next          = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign bus.busy           = (r_state != IDLE);
   assign bus.mem_addr       = r_addr;
   assign bus.mem_dataIn     = r_wdata;
   assign bus.mem_isIndirect = r_ind;
   assign bus.f_rdata        = r_f_rdata;
   assign bus.d_rdata        = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a
// transaction-level model of grant order, latency and data.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int RW = 8;
   localparam int AW = 8;
   localparam int T  = 8;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ramWidth(RW), .addrSize(AW)) bus ();

   mem_port_arbiter #(
      .ramWidth      (RW),
      .addrSize      (AW),
      .timeoutCycles (T)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   bit          m_last_d = 1'b1;
   logic [RW-1:0] m_frd = '0;
   logic [RW-1:0] m_drd = '0;

   bit          fp = 1'b0, dp = 1'b0;
   bit          fi = 1'b0, di = 1'b0, dwe = 1'b0;
   logic [AW-1:0] fa = '0, da = '0;
   logic [RW-1:0] dw = '0;
   int          w = 2;
   bit          stale = 1'b0;
   logic [RW-1:0] rd = '0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic drive_reqs();
      bus.f_req      = fp;
      bus.f_addr     = fa;
      bus.f_indirect = fi;
      bus.d_req      = dp;
      bus.d_we       = dwe;
      bus.d_addr     = da;
      bus.d_wdata    = dw;
      bus.d_indirect = di;
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the
   // negedge of the IDLE cycle following the ack.
   task automatic run_one();
      bit gd, err, wr, ind;
      int ack_c, k;
      logic [1:0] cmd;
      logic [AW-1:0] a;
      drive_reqs();
      gd    = (fp && dp) ? !m_last_d : dp;
      wr    = gd && dwe;
      a     = gd ? da : fa;
      ind   = gd ? di : fi;
      cmd   = wr ? 2'b10 : 2'b01;
      err   = (w > T);
      ack_c = err ? T + 2 : w + 2;
      bus.mem_dataOut   = rd;
      bus.mem_dataReady = 1'b0;
      for (int c = 1; c <= ack_c + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("start", bus.mem_start, 1);
            chk("cmd", bus.mem_cntrl, cmd);
            chk("addr", bus.mem_addr, a);
            chk("ind", bus.mem_isIndirect, ind);
            chk("busy", bus.busy, 1);
            if (wr) chk("wdata", bus.mem_dataIn, dw);
            // inputs after grant must not matter
            if (gd) begin
               bus.d_addr     = AW'($urandom);
               bus.d_wdata    = RW'($urandom);
               bus.d_we       = 1'($urandom);
               bus.d_indirect = 1'($urandom);
               if ($urandom_range(0, 1) == 1) bus.d_req = 1'b0;
            end else begin
               bus.f_addr     = AW'($urandom);
               bus.f_indirect = 1'($urandom);
               if ($urandom_range(0, 1) == 1) bus.f_req = 1'b0;
            end
         end else if (c < ack_c) begin
            chk("start0", bus.mem_start, 0);
            chk("noack", {bus.f_ack, bus.d_ack}, 0);
            chk("cmdw", bus.mem_cntrl, cmd);
         end else if (c == ack_c) begin
            if (!err && !wr) begin
               if (gd) m_drd = rd;
               else    m_frd = rd;
            end
            m_last_d = gd;
            chk("f_ack", bus.f_ack, !gd);
            chk("d_ack", bus.d_ack, gd);
            chk("tmo", bus.timeout_err, err);
            chk("nop", bus.mem_cntrl, 0);
            chk("haddr", bus.mem_addr, a);
            chk("f_rdata", bus.f_rdata, m_frd);
            chk("d_rdata", bus.d_rdata, m_drd);
            if (gd) begin dp = 1'b0; bus.d_req = 1'b0; end
            else    begin fp = 1'b0; bus.f_req = 1'b0; end
         end else begin
            chk("idle", bus.busy, 0);
            chk("ackclr", {bus.f_ack, bus.d_ack, bus.timeout_err}, 0);
         end
         k = c - 1;
         if (c >= ack_c)  bus.mem_dataReady = 1'b0;
         else if (c == 1) bus.mem_dataReady = stale;
         else bus.mem_dataReady = (k >= w) || (stale && k == 1);
      end
   endtask

   task automatic reset_mid();
      fp = 1'b1; fa = 8'h5A; fi = 1'b1; dp = 1'b0;
      drive_reqs();
      bus.mem_dataReady = 1'b0;
      @(negedge clk);
      fp = 1'b0; bus.f_req = 1'b0;
      @(negedge clk);
      #2 clr = 1'b1;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_cmd", bus.mem_cntrl, 0);
      chk("rst_start", bus.mem_start, 0);
      chk("rst_ack", {bus.f_ack, bus.d_ack, bus.timeout_err}, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_din", bus.mem_dataIn, 0);
      chk("rst_frd", bus.f_rdata, 0);
      chk("rst_drd", bus.d_rdata, 0);
      m_last_d = 1'b1; m_frd = '0; m_drd = '0;
      @(negedge clk);
      clr = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("rst_quiet", {bus.f_ack, bus.d_ack, bus.busy}, 0);
      end
   endtask

   initial begin
      drive_reqs();
      bus.mem_dataOut   = '0;
      bus.mem_dataReady = 1'b0;
      repeat (2) @(negedge clk);
      chk("r_busy", bus.busy, 0);
      chk("r_start", bus.mem_start, 0);
      chk("r_cmd", bus.mem_cntrl, 0);
      chk("r_ack", {bus.f_ack, bus.d_ack, bus.timeout_err}, 0);
      chk("r_addr", bus.mem_addr, 0);
      chk("r_rdata", {bus.f_rdata, bus.d_rdata}, 0);
      clr = 1'b0;

      fp = 1; fa = 8'h10; fi = 0; w = 2; stale = 0; rd = 8'hA5;
      run_one();
      dp = 1; da = 8'h22; dw = 8'h3C; dwe = 1; di = 1;
      w = 3; stale = 0; rd = 8'hFF;
      run_one();
      dwe = 0; da = 8'h44; fa = 8'h11;
      for (int i = 0; i < 4; i++) begin
         fp = 1; dp = 1; w = 2; stale = 0;
         rd = 8'h80 | RW'(i);
         run_one();
      end
      dp = 1; da = 8'h40; dwe = 0; w = T + 1; stale = 0; rd = 8'h77;
      run_one();
      fp = 1; fa = 8'h30; w = 2; stale = 1; rd = 8'h5C;
      run_one();
      fp = 1; fa = 8'h31; w = T; stale = 0; rd = 8'hC3;
      run_one();

      reset_mid();

      repeat (60) begin
         if (!fp && $urandom_range(0, 3) != 0) begin
            fp = 1; fa = AW'($urandom); fi = 1'($urandom);
         end
         if (!dp && $urandom_range(0, 3) != 0) begin
            dp = 1; da = AW'($urandom); dw = RW'($urandom);
            dwe = 1'($urandom); di = 1'($urandom);
         end
         if (!fp && !dp) begin
            fp = 1; fa = AW'($urandom); fi = 1'($urandom);
         end
         w     = $urandom_range(2, T + 1);
         stale = ($urandom_range(0, 3) == 0);
         rd    = RW'($urandom);
         run_one();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
